// File: rtl/baby_loader_if.sv
// Byte-stream receive handshake and store write port of the Baby loader.
// master drives the byte stream and consumes store writes; slave is the loader.
interface baby_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  ram_addr,
        input  ram_din,
        input  ram_we
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output ram_addr,
        output ram_din,
        output ram_we
    );
endinterface

// File: rtl/baby_loader.sv
// Serial frame loader for the Baby store: header, little-endian words, XOR checksum.
// Writes each word one cycle after its last byte and releases the core on a good frame.
module baby_loader #(
    parameter logic [7:0]  HEADER = 8'h55,
    parameter int unsigned WORDS  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    baby_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         start,
    output logic         err,
    output logic [5:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [4:0]  word_idx_q, word_idx_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        ready_q, ready_d;
    logic        hold_q, hold_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic [5:0]  loaded_q, loaded_d;
    logic        accept;

    assign accept = bus.rx_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            ready_q    <= 1'b0;
            hold_q     <= 1'b1;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            loaded_q   <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            ready_q    <= ready_d;
            hold_q     <= hold_d;
            start_q    <= start_d;
            err_q      <= err_d;
            loaded_q   <= loaded_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        hold_d     = hold_q;
        err_d      = err_q;
        // words_loaded counts completed store writes
        loaded_d   = we_q ? loaded_q + 6'd1 : loaded_q;

        unique case (state_q)
            IDLE: begin
                if (accept && bus.rx_data == HEADER) begin
                    state_d    = DATA;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    xor_d      = '0;
                    loaded_d   = '0;
                    hold_d     = 1'b1;
                    err_d      = 1'b0;
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: word_d[7:0]   = bus.rx_data;
                        2'd1: word_d[15:8]  = bus.rx_data;
                        2'd2: word_d[23:16] = bus.rx_data;
                        2'd3: begin
                            // last byte bypasses word_q so the write issues on the next cycle
                            we_d       = 1'b1;
                            addr_d     = word_idx_q;
                            din_d      = {bus.rx_data, word_q};
                            word_idx_d = word_idx_q + 5'd1;
                            if (word_idx_q == LAST_IDX) begin
                                state_d = CSUM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_d = (state_d == DONE);
        if (state_d == DONE) begin
            hold_d = 1'b0;
        end
        if (state_d == ERROR) begin
            err_d = 1'b1;
        end
        ready_d = (state_d == IDLE) || (state_d == DATA) || (state_d == CSUM);
    end

    assign bus.rx_ready  = ready_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_din   = din_q;
    assign bus.ram_we    = we_q;
    assign cpu_hold      = hold_q;
    assign start         = start_q;
    assign err           = err_q;
    assign words_loaded  = loaded_q;

endmodule

// File: tb/tb_baby_loader.sv
// Randomised frame bench for baby_loader against a frame-level store/checksum model.
module tb_baby_loader;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data_t = '0;
    logic        rx_valid_t = 1'b0;
    logic        sel_t = 1'b0;
    logic        rdy_mux;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned n_start = 0;
    int unsigned n_start4 = 0;

    logic        hold, start, err;
    logic [5:0]  wl;
    logic        hold4, start4, err4;
    logic [5:0]  wl4;

    wr_t         exp_q[$];
    wr_t         exp4_q[$];
    logic [31:0] store [32];
    logic [31:0] exp_store [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baby_loader_if bus ();
    baby_loader_if bus4 ();

    assign bus.rx_data   = rx_data_t;
    assign bus.rx_valid  = rx_valid_t & ~sel_t;
    assign bus4.rx_data  = rx_data_t;
    assign bus4.rx_valid = rx_valid_t & sel_t;
    assign rdy_mux       = sel_t ? bus4.rx_ready : bus.rx_ready;

    baby_loader #(.HEADER(8'h55), .WORDS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cpu_hold     (hold),
        .start        (start),
        .err          (err),
        .words_loaded (wl)
    );

    baby_loader #(.HEADER(8'h55), .WORDS(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus4),
        .cpu_hold     (hold4),
        .start        (start4),
        .err          (err4),
        .words_loaded (wl4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Store model and write-timing monitor for both loaders.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("we", 64'(bus.ram_we), 64'd1);
            check("addr", 64'(bus.ram_addr), 64'(exp_q[0].addr));
            check("din", 64'(bus.ram_din), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else if (bus.ram_we !== 1'b0) begin
            check("spurious_we", 64'(bus.ram_we), 64'd0);
        end
        if (bus.ram_we === 1'b1) store[bus.ram_addr] <= bus.ram_din;
        if (exp4_q.size() > 0 && exp4_q[0].cyc == cyc) begin
            check("we4", 64'(bus4.ram_we), 64'd1);
            check("addr4", 64'(bus4.ram_addr), 64'(exp4_q[0].addr));
            check("din4", 64'(bus4.ram_din), 64'(exp4_q[0].data));
            void'(exp4_q.pop_front());
        end else if (bus4.ram_we !== 1'b0) begin
            check("spurious_we4", 64'(bus4.ram_we), 64'd0);
        end
        if (start === 1'b1) n_start++;
        if (start4 === 1'b1) n_start4++;
    end

    // Returns just after the accepting edge with rx_valid still high.
    task automatic send_byte(input logic [7:0] b, input bit gap, output int unsigned acc);
        bit got;
        got = 1'b0;
        acc = 0;
        @(negedge clk);
        if (gap) begin
            rx_valid_t = 1'b0;
            @(negedge clk);
        end
        rx_data_t  = b;
        rx_valid_t = 1'b1;
        for (int t = 0; t < 20; t++) begin
            logic r;
            r = rdy_mux;
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("rx_ready_timeout", 64'(rdy_mux), 64'd1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid_t = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] w [32], input int unsigned nbytes,
                              input bit do_csum, input logic [7:0] flip, input bit gaps);
        int unsigned acc;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] cur;
        x = '0;
        sel_t = sel;
        send_byte(8'h55, gaps, acc);
        for (int unsigned k = 0; k < nbytes; k++) begin
            cur = w[k / 4];
            b = cur[8 * (k % 4) +: 8];
            x ^= b;
            send_byte(b, gaps, acc);
            if (k % 4 == 3) begin
                if (sel) begin
                    exp4_q.push_back('{k / 4, cur, acc});
                end else begin
                    exp_q.push_back('{k / 4, cur, acc});
                    exp_store[k / 4] = cur;
                end
            end
        end
        if (do_csum) send_byte(x ^ flip, gaps, acc);
        go_idle();
    endtask

    // Called at the negedge of the DONE/ERROR cycle of a 32-word frame.
    task automatic check_result(input string tag, input bit good, input int unsigned starts_before);
        check({tag, "_start_pulse"}, 64'(start), 64'(good));
        check({tag, "_hold"}, 64'(hold), 64'(!good));
        check({tag, "_err"}, 64'(err), 64'(!good));
        @(negedge clk);
        @(negedge clk);
        check({tag, "_start_low"}, 64'(start), 64'd0);
        check({tag, "_start_count"}, 64'(n_start), 64'(starts_before + (good ? 1 : 0)));
        check({tag, "_words_loaded"}, 64'(wl), 64'd32);
        check({tag, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w [32];
        logic [31:0] w4 [32];
        int unsigned s0;
        int unsigned acc;

        for (int i = 0; i < 32; i++) begin
            store[i]     = 32'hDEAD_0000 + 32'(i);
            exp_store[i] = 32'hDEAD_0000 + 32'(i);
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_hold", 64'(hold), 64'd1);
        check("rst_start", 64'(start), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_we", 64'(bus.ram_we), 64'd0);
        check("rst_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_din", 64'(bus.ram_din), 64'd0);
        check("rst_wl", 64'(wl), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        check("ready_after_reset", 64'(bus.rx_ready), 64'd1);

        // Good frame A0000000+i
        for (int i = 0; i < 32; i++) w[i] = 32'hA000_0000 + 32'(i);
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h00, 1'b0);
        check_result("good", 1'b1, s0);

        // Same frame, corrupted checksum
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h01, 1'b0);
        check_result("badsum", 1'b0, s0);

        // Junk before the header is discarded
        sel_t = 1'b0;
        send_byte(8'h00, 1'b0, acc);
        send_byte(8'hFF, 1'b0, acc);
        go_idle();
        repeat (2) @(negedge clk);
        check("junk_wl_held", 64'(wl), 64'd32);
        check("junk_err_held", 64'(err), 64'd1);
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h00, 1'b0);
        check_result("junk_then_good", 1'b1, s0);

        // rx_valid toggling every other cycle
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h00, 1'b1);
        check_result("gapped", 1'b1, s0);

        // Random words with header-valued data bytes
        for (int i = 0; i < 32; i++) w[i] = $urandom;
        w[3] = 32'h5555_5555;
        w[7][15:8] = 8'h55;
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h00, 1'b0);
        check_result("random", 1'b1, s0);

        for (int i = 0; i < 32; i++) begin
            check("store_after_random", 64'(store[i]), 64'(exp_store[i]));
        end

        // Partial frame interrupted by reset after word 5's 2nd byte
        for (int i = 0; i < 32; i++) w[i] = $urandom;
        send_frame(1'b0, w, 22, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("partial_wl", 64'(wl), 64'd5);
        for (int i = 0; i < 7; i++) begin
            check("partial_store", 64'(store[i]), 64'(exp_store[i]));
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_hold", 64'(hold), 64'd1);
        check("midreset_wl", 64'(wl), 64'd0);
        check("midreset_ready", 64'(bus.rx_ready), 64'd0);
        rst_n = 1'b1;

        // Reset arriving together with a word's 4th byte suppresses that write
        send_frame(1'b0, w, 3, 1'b0, 8'h00, 1'b0);
        rx_data_t  = 8'hC3;
        rx_valid_t = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        check("suppressed_we", 64'(bus.ram_we), 64'd0);
        rst_n      = 1'b1;
        rx_valid_t = 1'b0;
        @(negedge clk);
        check("suppressed_we_after", 64'(bus.ram_we), 64'd0);

        // New frame of 11111111 after the reset
        for (int i = 0; i < 32; i++) w[i] = 32'h1111_1111;
        s0 = n_start;
        send_frame(1'b0, w, 128, 1'b1, 8'h00, 1'b0);
        check_result("after_reset", 1'b1, s0);
        for (int i = 0; i < 32; i++) begin
            check("store_final", 64'(store[i]), 64'(exp_store[i]));
        end

        // Four-word loader
        for (int i = 0; i < 32; i++) w4[i] = $urandom;
        s0 = n_start4;
        send_frame(1'b1, w4, 16, 1'b1, 8'h00, 1'b0);
        check("w4_start", 64'(start4), 64'd1);
        check("w4_hold", 64'(hold4), 64'd0);
        check("w4_err", 64'(err4), 64'd0);
        repeat (2) @(negedge clk);
        check("w4_wl", 64'(wl4), 64'd4);
        check("w4_start_count", 64'(n_start4), 64'(s0 + 1));
        check("w4_writes_seen", 64'(exp4_q.size()), 64'd0);
        check("w4_addr_max", 64'(bus4.ram_addr), 64'd3);
        sel_t = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
